down_counter_timer: RTL and testbench

- Synchronous, loadable down-counter and countdown timer; the counting-down counterpart to the team's ripple up-counter.
- Loads a start value, then decrements once per enabled clock to zero and flags completion with a one-cycle DONE pulse.
- Fully synchronous: every flop is on CLK, with no derived or ripple clocks.
- Used as a delay/interval source for the lab FSMs and the display blocks.

---
 rtl/down_counter_timer.sv | 108 ++++++++++
 tb/tb_down_counter_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counter / countdown timer with one-cycle DONE pulse.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN for periodic (auto-reload) mode.
module down_counter_timer #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             done_r, done_nxt;
  logic             busy_c;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    done_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (LOAD) begin
          count_nxt  = LOAD_VAL;
          reload_nxt = LOAD_VAL;
        end else if (START) begin
          if (count != '0) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          state_nxt = ST_IDLE;
        end else if (PAUSE) begin
          state_nxt = ST_PAUSED;
        end else if (count > WIDTH'(1)) begin
          count_nxt = count - WIDTH'(1);
        end else begin
          // Terminal tick: the pulse is registered so DONE appears with the final Q
          done_nxt = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          count_nxt = reload;
`else
          count_nxt = '0;
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_PAUSED: begin
        if (ABORT) begin
          state_nxt = ST_IDLE;
        end else if (!PAUSE) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (LOAD) begin
          count_nxt  = LOAD_VAL;
          reload_nxt = LOAD_VAL;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == ST_RUN) || (state == ST_PAUSED);
  end

  assign Q    = count;
  assign BUSY = busy_c;
  assign DONE = done_r;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: a behavioural model predicts Q/BUSY/DONE
// for every edge, and an independent monitor compares them on the falling edge.
module tb_down_counter_timer;

  localparam int WIDTH = 3;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             CLK;
  logic             RESET;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic             START;
  logic             PAUSE;
  logic             ABORT;
  logic [WIDTH-1:0] Q;
  logic             BUSY;
  logic             DONE;

  typedef struct {
    int q;
    int busy;
    int done;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: remaining count, whether the timer is ticking or frozen,
  // and whether a completion pulse is showing this cycle.
  int mCount  = 0;
  int mReload = 0;
  bit mTicking = 0;
  bit mFrozen  = 0;
  bit mPulse   = 0;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .START(START),
    .PAUSE(PAUSE), .ABORT(ABORT), .Q(Q), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic modelEdge(input bit rst, input bit ld, input int lv,
                           input bit st, input bit ps, input bit ab);
    bit pulseNext;
    pulseNext = 1'b0;
    if (rst) begin
      mCount = 0; mReload = 0; mTicking = 0; mFrozen = 0;
    end else if (!mTicking && !mFrozen) begin
      if (ld) begin
        mCount = lv; mReload = lv;
      end else if (st && !mPulse) begin
        if (mCount == 0) pulseNext = 1'b1;
        else mTicking = 1'b1;
      end
    end else if (ab) begin
      mTicking = 0; mFrozen = 0;
    end else if (mFrozen) begin
      if (!ps) begin
        mFrozen = 0; mTicking = 1;
      end
    end else if (ps) begin
      mTicking = 0; mFrozen = 1;
    end else if (mCount > 1) begin
      mCount = mCount - 1;
    end else begin
      pulseNext = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      mCount = mReload;
`else
      mCount = 0;
      mTicking = 0;
`endif
    end
    mPulse = pulseNext;
  endtask

  task automatic applyStimulus(input bit rst, input bit ld, input int lv,
                               input bit st, input bit ps, input bit ab);
    exp_t e;
    RESET = rst; LOAD = ld; LOAD_VAL = lv[WIDTH-1:0];
    START = st; PAUSE = ps; ABORT = ab;
    modelEdge(rst, ld, lv, st, ps, ab);
    e.q = mCount; e.busy = int'(mTicking || mFrozen); e.done = int'(mPulse);
    @(posedge CLK);
    sbq.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checkOutput("Q", int'(Q), e.q);
      checkOutput("BUSY", int'(BUSY), e.busy);
      checkOutput("DONE", int'(DONE), e.done);
    end
  end

  initial begin
    int drainWait;
    RESET = 1'b1; LOAD = 0; LOAD_VAL = '0; START = 0; PAUSE = 0; ABORT = 0;
    @(posedge CLK); #1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 1, 0, 0);

    // Reset mid-count, then a start with Q=0 gives a single pulse
    applyStimulus(0, 1, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle(3);

    // Plain count from 5
    applyStimulus(0, 1, 5, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle(7);

    // Pause for 3 cycles after the first decrement
    applyStimulus(0, 1, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    idle(6);

    // LOAD+START together, LOAD ignored in RUN, ABORT at Q=2
    applyStimulus(0, 1, 6, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle(3);
    applyStimulus(0, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    idle(2);

    // Full range, then zero-length count
    applyStimulus(0, 1, MAXV, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle(10);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle(2);

    // Period of 3 (one-shot or periodic, depending on build)
    applyStimulus(0, 1, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idle(10);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 59) == 0,
                    $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, MAXV)),
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 24) == 0);
    end
    idle(2);

    drainWait = 0;
    while (sbq.size() > 0 && drainWait < 10) begin
      @(negedge CLK);
      drainWait++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
